// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and constants for the BCD countdown timer
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_ALARM
  } state_t;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;
  localparam int   KEY_W   = 10;

endpackage

// File: rtl/bcd_key_encoder.sv
// rtl/bcd_key_encoder.sv - one-hot decimal key to BCD digit with single-key valid
module bcd_key_encoder
  import timer_pkg::*;
(
  input  logic [KEY_W-1:0] d,
  output bcd_t             digit,
  output logic             valid
);

  // Digit is the index of the lowest set bit; valid only when exactly one bit is set.
  always_comb begin
    digit = '0;
    for (int i = KEY_W - 1; i >= 0; i--) begin
      if (d[i]) begin
        digit = bcd_t'(i);
      end
    end
    valid = (d != '0) && ((d & (d - {{(KEY_W-1){1'b0}}, 1'b1})) == '0);
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// rtl/bcd_countdown_timer.sv - two-digit BCD countdown timer; TIMER_AUTO_CLEAR_EN enables alarm self-clear
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int ALARM_LEN = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [KEY_W-1:0] d,
  input  logic             start,
  input  logic             stop,
  output bcd_t             high,
  output bcd_t             low,
  output logic             alarm
);

  localparam logic [15:0] TICK_LAST = 16'(TICK_DIV - 1);

  if (TICK_DIV < 1 || TICK_DIV > 65535 || ALARM_LEN < 1 || ALARM_LEN > 65536) begin : g_param_check
    $error("bcd_countdown_timer: TICK_DIV or ALARM_LEN out of range");
  end

  state_t           state_q, state_d;
  bcd_t             high_d, low_d;
  logic             alarm_d;
  logic [15:0]      presc_q, presc_d;
  logic [KEY_W-1:0] d_q, d_qq;
  logic             stop_q;
  logic             stop_rise;
  logic             nonzero;
  logic             key_press;
  bcd_t             key_digit;
  logic             key_valid;

`ifdef TIMER_AUTO_CLEAR_EN
  localparam logic [15:0] ALARM_LOAD = 16'(ALARM_LEN - 1);
  logic [15:0] alarm_cnt_q, alarm_cnt_d;
`endif

  // Keys are registered first, so a press is judged on the registered key
  // against the one before it; this gives the one-cycle key-to-digit latency.
  bcd_key_encoder u_key_enc (
    .d     (d_q),
    .digit (key_digit),
    .valid (key_valid)
  );

  assign key_press = key_valid && (d_qq == '0);
  assign stop_rise = stop && !stop_q;
  assign nonzero   = (high != '0) || (low != '0);

  // Next-state and datapath decisions; stop takes priority over start everywhere.
  always_comb begin
    state_d = state_q;
    high_d  = high;
    low_d   = low;
    alarm_d = alarm;
    presc_d = presc_q;
`ifdef TIMER_AUTO_CLEAR_EN
    alarm_cnt_d = alarm_cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (stop) begin
          high_d = '0;
          low_d  = '0;
        end else if (start && nonzero) begin
          state_d = ST_RUN;
          presc_d = '0;
        end else if (key_press) begin
          high_d = low;
          low_d  = key_digit;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_PAUSE;
        end else if (presc_q != TICK_LAST) begin
          presc_d = presc_q + 16'd1;
        end else begin
          presc_d = '0;
          if (nonzero) begin
            if (low == '0) begin
              low_d  = BCD_MAX;
              high_d = high - 4'd1;
            end else begin
              low_d = low - 4'd1;
            end
            if (high == '0 && low == 4'd1) begin
              state_d = ST_ALARM;
              alarm_d = 1'b1;
`ifdef TIMER_AUTO_CLEAR_EN
              alarm_cnt_d = ALARM_LOAD;
`endif
            end
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          if (stop_rise) begin
            state_d = ST_IDLE;
          end
        end else if (start) begin
          state_d = ST_RUN;
        end
      end
      ST_ALARM: begin
        if (stop_rise) begin
          state_d = ST_IDLE;
          alarm_d = 1'b0;
        end
`ifdef TIMER_AUTO_CLEAR_EN
        else if (alarm_cnt_q == '0) begin
          state_d = ST_IDLE;
          alarm_d = 1'b0;
        end else begin
          alarm_cnt_d = alarm_cnt_q - 16'd1;
        end
`else
        // alarm holds until an operator stop.
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, digits, prescaler and input history registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      high    <= '0;
      low     <= '0;
      alarm   <= 1'b0;
      presc_q <= '0;
      d_q     <= '0;
      d_qq    <= '0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      high    <= high_d;
      low     <= low_d;
      alarm   <= alarm_d;
      presc_q <= presc_d;
      d_q     <= d;
      d_qq    <= d_q;
      stop_q  <= stop;
    end
  end

`ifdef TIMER_AUTO_CLEAR_EN
  // Alarm duration down-counter, loaded when the count reaches 00.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      alarm_cnt_q <= '0;
    end else begin
      alarm_cnt_q <= alarm_cnt_d;
    end
  end
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb/tb_bcd_countdown_timer.sv - scoreboard bench for bcd_countdown_timer
module tb_bcd_countdown_timer;
  import timer_pkg::*;

  logic             clk = 1'b0;
  logic             reset;
  logic [KEY_W-1:0] d;
  logic             start;
  logic             stop;
  bcd_t             high, low, high3, low3;
  logic             alarm, alarm3;

  int checks = 0;
  int errors = 0;

  logic [8:0] exp_q[$];
  logic [8:0] exp3_q[$];
  logic [8:0] exp_v;
  logic [8:0] got_v;

  always #5 clk = ~clk;

  bcd_countdown_timer #(.TICK_DIV(1), .ALARM_LEN(16)) u_dut (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .start (start),
    .stop  (stop),
    .high  (high),
    .low   (low),
    .alarm (alarm)
  );

  bcd_countdown_timer #(.TICK_DIV(3), .ALARM_LEN(16)) u_dut3 (
    .clk   (clk),
    .reset (reset),
    .d     (d),
    .start (start),
    .stop  (stop),
    .high  (high3),
    .low   (low3),
    .alarm (alarm3)
  );

  function automatic logic [8:0] bcd_of(input int v, input logic a);
    return {4'(v / 10), 4'(v % 10), a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_key(input int k);
    d = '0;
    d[k] = 1'b1;
    tick();
    d = '0;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d = '0;
    start = 1'b0;
    stop = 1'b0;
    repeat (3) tick();
    exp_q.push_back(bcd_of(0, 1'b0));
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_hold: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    reset = 1'b1;
    exp_q.push_back(bcd_of(0, 1'b0));
    tick();
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL reset_release: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
  endtask

  task automatic test_keys();
    int prev = 0;
    for (int k = 0; k < 10; k++) begin
      d = '0;
      d[k] = 1'b1;
      tick();
      d = '0;
      exp_q.push_back(bcd_of(prev * 10 + k, 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL key_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", k,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
      tick();
      tick();
      prev = k;
    end
  endtask

  task automatic test_held_key();
    d = '0;
    d[3] = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bcd_of(93, 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL held_key_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", i,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    d = '0;
    tick();
    tick();
  endtask

  task automatic test_multi_hot();
    d = 10'b0000000110;
    for (int i = 0; i < 4; i++) begin
      if (i == 2) d = '0;
      exp_q.push_back(bcd_of(93, 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL multi_hot_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", i,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_count_and_pause();
    start = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(bcd_of(93 - i, 1'b0));
      tick();
      if (i == 3) start = 1'b0;
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL count_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", i,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    stop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(bcd_of(86, 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL pause_hold_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", i,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask

  task automatic test_resume_to_alarm();
    stop = 1'b0;
    tick();
    start = 1'b1;
    for (int j = 0; j <= 86; j++) begin
      exp_q.push_back(bcd_of(86 - j, j == 86));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL resume_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    for (int j = 0; j < 5; j++) begin
      exp_q.push_back(bcd_of(0, 1'b1));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL alarm_hold_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_alarm_ack();
    stop = 1'b1;
    for (int j = 0; j < 5; j++) begin
      if (j == 2) begin
        stop = 1'b0;
        start = 1'b1;
      end
      exp_q.push_back(bcd_of(0, 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL alarm_ack_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    start = 1'b0;
    tick();
  endtask

`ifdef TIMER_AUTO_CLEAR_EN
  task automatic test_auto_clear();
    press_key(1);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int j = 0; j <= 16; j++) begin
      exp_q.push_back(bcd_of(0, j < 16));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL auto_clear_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
  endtask
`endif

  task automatic test_start_stop_same();
    // Each step: start, stop, expected value after the edge.
    int st_tab[9] = '{1, 1, 1, 1, 0, 0, 0, 0, 0};
    int sp_tab[9] = '{0, 0, 1, 1, 0, 1, 0, 1, 0};
    int ex_tab[9] = '{42, 41, 41, 41, 41, 41, 41, 0, 0};
    exp_q.push_back(bcd_of(42, 1'b0));
    press_key(4);
    press_key(2);
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL entry_42: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    for (int i = 0; i < 9; i++) begin
      start = st_tab[i][0];
      stop = sp_tab[i][0];
      exp_q.push_back(bcd_of(ex_tab[i], 1'b0));
      tick();
      exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL start_stop_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", i,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    start = 1'b0;
    stop = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_q.push_back(bcd_of(57, 1'b0));
    press_key(5);
    press_key(7);
    start = 1'b1;
    tick();
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL run_57: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    #2;
    reset = 1'b0;
    exp_q.push_back(bcd_of(0, 1'b0));
    exp3_q.push_back(bcd_of(0, 1'b0));
    #1;
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    exp_v = exp3_q.pop_front(); got_v = {high3, low3, alarm3}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL async_reset_div3: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
    tick();
    start = 1'b0;
    reset = 1'b1;
    exp_q.push_back(bcd_of(0, 1'b0));
    tick();
    tick();
    exp_v = exp_q.pop_front(); got_v = {high, low, alarm}; checks++;
    if (got_v !== exp_v) begin
      errors++;
      $display("FAIL post_reset_idle: got %h%h alarm=%b, expected %h%h alarm=%b",
               got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
    end
  endtask

  task automatic test_prescaler();
    press_key(1);
    press_key(2);
    start = 1'b1;
    for (int j = 0; j < 8; j++) begin
      exp3_q.push_back(bcd_of(12 - j / 3, 1'b0));
      tick();
      start = 1'b0;
      exp_v = exp3_q.pop_front(); got_v = {high3, low3, alarm3}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL prescale_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    stop = 1'b1;
    for (int j = 0; j < 4; j++) begin
      exp3_q.push_back(bcd_of(10, 1'b0));
      tick();
      exp_v = exp3_q.pop_front(); got_v = {high3, low3, alarm3}; checks++;
      if (got_v !== exp_v) begin
        errors++;
        $display("FAIL prescale_pause_%0d: got %h%h alarm=%b, expected %h%h alarm=%b", j,
                 got_v[8:5], got_v[4:1], got_v[0], exp_v[8:5], exp_v[4:1], exp_v[0]);
      end
    end
    stop = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_keys();
    test_held_key();
    test_multi_hot();
    test_count_and_pause();
    test_resume_to_alarm();
    test_alarm_ack();
`ifdef TIMER_AUTO_CLEAR_EN
    test_auto_clear();
`endif
    test_start_stop_same();
    test_async_reset();
    test_prescaler();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_countdown_timer.md
# bcd_countdown_timer

Two-digit BCD countdown timer that sits behind the keypad/start/stop controls: it accepts one-hot decimal key presses to build a value 00–99, counts down one step per prescaled tick after `start`, suspends on `stop`, and raises `alarm` on reaching 00. It is the design-side counterpart of the existing timer test bench and drives the `high`/`low` digit and `alarm` signals that bench checks.

## Interface
- `TICK_DIV`, default 1: clock cycles per count decrement; legal range 1 to 2^16-1.
- `ALARM_LEN`, default 16: cycles `alarm` stays high before self-clearing; used only with `TIMER_AUTO_CLEAR_EN`.

- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low; 0 = reset.
- `d`  in  10  one-hot decimal key, bit k = digit k; all-zero = no key.
- `start`  in  1  level, synchronous; starts or resumes the count.
- `stop`  in  1  level, synchronous; pauses, clears, or acknowledges the alarm.
- `high`  out  4  BCD tens digit.
- `low`  out  4  BCD units digit.
- `alarm`  out  1  count reached 00 while running.

## Operation
- States: IDLE, RUN, PAUSE, ALARM. Reset forces IDLE, `high`=0, `low`=0, `alarm`=0, prescaler=0, key history=0.
- Key entry is accepted in IDLE only. A key is one new press: `d` is one-hot and the registered previous `d` was zero. On a new press, `high`<=`low` and `low`<=k (shift-in). Multi-hot `d` and held keys are ignored.
- IDLE: `start` with {high,low}!=00 goes to RUN and clears the prescaler. `start` at 00 is ignored. `stop` clears both digits to 0.
- RUN: the prescaler counts 0..TICK_DIV-1. At wrap it issues a decrement: if `low`==0 then `low`=9 and `high`=`high`-1, otherwise `low`=`low`-1. A decrement producing 00 goes to ALARM with `alarm`=1. `stop` goes to PAUSE.
- PAUSE: digits and prescaler are held. `start` returns to RUN and the prescaler resumes. `stop` is ignored while held; a fresh `stop` rising edge goes to IDLE with the value kept.
- ALARM: digits stay at 00. A `stop` rising edge goes to IDLE and clears `alarm`. `start` is ignored.
- Simultaneous `start` and `stop`: `stop` wins in every state.
- BCD invariant: digits never leave 0–9. No decrement is issued at 00.

## Timing
- All outputs are registered.
- Key press: `d` sampled at edge N, digits updated at edge N+1.
- `start` sampled at edge N: state=RUN at N. The first decrement is visible at edge N+TICK_DIV, then one every TICK_DIV cycles.
- `stop` sampled in RUN at edge N: no decrement at N or later. The digits at N are held.
- `alarm` rises on the same edge the digits become 00.
- `reset` low mid-count takes effect asynchronously. It deasserts synchronously into IDLE with 00.

## Configuration
- `TIMER_AUTO_CLEAR_EN` defined: ALARM also exits to IDLE after `ALARM_LEN` cycles with `alarm` cleared, using a dedicated down-counter. `stop` still exits early.
- `TIMER_AUTO_CLEAR_EN` undefined: `alarm` holds until `stop`. The counter and `ALARM_LEN` logic are absent.

## Structure
- The shared package `timer_pkg` holds:
  - the state enum;
  - the 4-bit BCD digit type;
  - the constants `BCD_MAX`=9 and `KEY_W`=10.
- One sub-module, `bcd_key_encoder`: combinational one-hot-to-BCD conversion plus a `valid` output (exactly one bit set). It is instantiated once.

## Test plan
- Reset, then keys 0..9 one per 4 cycles: after each key, `low`=k and `high`=previous key. After key 9, output is 89; then key 3 gives 93.
- Value 93, TICK_DIV=1, `start` pulse of 4 cycles: count reads 92, 91, …, 90 → 89 borrow correct. After 8 cycles, `stop`=1 freezes the digits for 3 or more cycles.
- From PAUSE, `stop`=0, then `start`: the count resumes to 00. `alarm`=1 on that edge and stays 1 for 4 or more cycles (macro off).
- In ALARM, a 2-cycle `stop` pulse: `alarm`=0 next edge, state IDLE, digits 00. `start` afterwards is ignored.
- `start` and `stop` high on the same cycle in RUN gives PAUSE. Multi-hot `d`=10'b0000000110 in IDLE leaves the digits unchanged.
- `reset` low mid-RUN at 57: `high`, `low` and `alarm` become 0 immediately. With `TIMER_AUTO_CLEAR_EN` and ALARM_LEN=16, `alarm` drops after exactly 16 cycles.
